// File: rtl/vc_input_buffer.sv
// Per-port virtual-channel input buffer: NUM_VCS FIFOs, arbiter requests, registered pop and credit.
// Define VC_BUF_ERR_EN to enable the sticky protocol-error flag; otherwise err is tied to 0.
module vc_input_buffer #(
    parameter int NUM_VCS = 4,
    parameter int DEPTH   = 4,
    parameter int FLIT_W  = 32,
    localparam int VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flit_valid,
    input  logic [VC_W-1:0]   flit_vc,
    input  logic [FLIT_W-1:0] flit_data,
    output logic [NUM_VCS-1:0] requests,
    input  logic [NUM_VCS-1:0] grants,
    output logic              out_valid,
    output logic [VC_W-1:0]   out_vc,
    output logic [FLIT_W-1:0] out_data,
    output logic              credit_valid,
    output logic [VC_W-1:0]   credit_vc,
    output logic              err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] mem [NUM_VCS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VCS];
    logic [PTR_W-1:0]  rd_ptr [NUM_VCS];
    logic [CNT_W-1:0]  count  [NUM_VCS];

    logic [NUM_VCS-1:0] push_sel;
    logic [NUM_VCS-1:0] push_en;
    logic [NUM_VCS-1:0] pop_sel;
    logic               one_hot;
    logic               pop_ok;
    logic [VC_W-1:0]    pop_vc;
    logic [FLIT_W-1:0]  head;

    assign one_hot = (grants != '0) && ((grants & (grants - 1'b1)) == '0);
    assign pop_ok  = |pop_sel;
    assign head    = mem[pop_vc][rd_ptr[pop_vc]];

    always_comb begin
        push_sel = '0;
        push_en  = '0;
        pop_sel  = '0;
        requests = '0;
        pop_vc   = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            requests[v] = (count[v] != '0);
            push_sel[v] = flit_valid && (flit_vc == VC_W'(v));
            pop_sel[v]  = one_hot && grants[v] && (count[v] != '0);
            if (grants[v])
                pop_vc = VC_W'(v);
        end
        // A full VC still accepts a flit when its head leaves in the same cycle
        for (int v = 0; v < NUM_VCS; v++)
            push_en[v] = push_sel[v] &&
                         ((count[v] != CNT_W'(DEPTH)) || pop_sel[v]);
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VCS; v++)
            if (push_en[v])
                mem[v][wr_ptr[v]] <= flit_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                count[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (push_en[v])
                    wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
                if (pop_sel[v])
                    rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
                case ({push_en[v], pop_sel[v]})
                    2'b10:   count[v] <= count[v] + CNT_W'(1);
                    2'b01:   count[v] <= count[v] - CNT_W'(1);
                    default: count[v] <= count[v];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_vc       <= '0;
            out_data     <= '0;
            credit_valid <= 1'b0;
            credit_vc    <= '0;
        end else begin
            out_valid    <= pop_ok;
            credit_valid <= pop_ok;
            if (pop_ok) begin
                out_vc    <= pop_vc;
                out_data  <= head;
                credit_vc <= pop_vc;
            end
        end
    end

`ifdef VC_BUF_ERR_EN
    logic err_hit;

    // Any nonzero grant that does not pop covers both multi-hot and empty-VC grants
    assign err_hit = (flit_valid && (push_en == '0)) ||
                     ((grants != '0) && !pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (err_hit)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
